la_capture_fsm: RTL and testbench
=================================

// Module: la_capture_fsm
// PURPOSE
//  Parametrised capture controller for the logic analyzer core; successor to the fixed-width,
//  fixed-depth, trigger-only FSM register block. It sits on the daisy-chained register bus
//  between the trigger block and the sample memory. It sequences pre-trigger/post-trigger
//  capture into a circular sample memory, with three trigger modes and a programmable
//  trigger location. It drives the memory write port; a separate sample-memory block serves readback.
// PARAMETERS
//  BASE_ADDR     0     first bus address of this block's 7 registers
//  SAMPLE_WIDTH  8     probe bus width, 1..256
//  SAMPLE_DEPTH  1024  sample memory depth, 2..65535, need not be a power of two
// PORTS
//  clk         in   1                 system clock; all logic on posedge
//  rst         in   1                 asynchronous reset, active-high
//  probe_i     in   SAMPLE_WIDTH      concatenated probes
//  trig_i      in   1                 trigger condition from trigger block, combinational
//  addr_i      in   16                bus in: address
//  wdata_i     in   16                bus in: write data
//  rdata_i     in   16                bus in: read data from upstream
//  rw_i        in   1                 bus in: 1 = write, 0 = read
//  valid_i     in   1                 bus in: transaction strobe, one cycle
//  addr_o/wdata_o/rdata_o/rw_o/valid_o  out  16/16/16/1/1  bus out to downstream
//  wr_addr_o   out  $clog2(DEPTH)     sample memory write address
//  wr_data_o   out  SAMPLE_WIDTH      sample memory write data
//  wr_en_o     out  1                 sample memory write enable
// BEHAVIOUR
//  Reset: all registers 0; state IDLE; all outputs 0. Asserting rst mid-capture aborts immediately.
//  Bus: every bus output is registered, with 1-cycle pass-through. For addr_i in BASE_ADDR..BASE_ADDR+6 with valid_i:
//   a write updates the RW register; a read replaces rdata_o with the register value, zero-extended.
//   Otherwise rdata_o=rdata_i. Writes to RO registers are ignored but still pass through.
//  Registers (offset): +0 STATE RO; +1 TRIGGER_MODE RW (0 SINGLE_SHOT, 1 INCREMENTAL, 2 IMMEDIATE;
//   3 is stored as 0); +2 TRIGGER_LOC RW, where writes >= DEPTH are stored as DEPTH-1; +3 REQUEST_START RW;
//   +4 REQUEST_STOP RW; +5 READ_POINTER RO (oldest sample address); +6 WRITE_POINTER RO.
//  Writes to +1/+2 are ignored unless STATE is IDLE or CAPTURED.
//  START/STOP act on the 0->1 transition of the stored bit, evaluated the cycle after the write.
//  States: 0 IDLE, 1 MOVE_TO_POSITION, 2 IN_POSITION, 3 CAPTURING, 4 CAPTURED.
//  Start edge in IDLE/CAPTURED: clear write pointer and counters, then branch on mode.
//   SINGLE_SHOT -> MOVE_TO_POSITION, or IN_POSITION directly if TRIGGER_LOC=0.
//   INCREMENTAL -> CAPTURING.
//   IMMEDIATE   -> CAPTURING; trig_i is ignored and DEPTH samples are taken every cycle.
//   A start edge in any other state is ignored.
//  MOVE_TO_POSITION: write every cycle. After TRIGGER_LOC writes -> IN_POSITION. trig_i is ignored.
//  IN_POSITION: write every cycle; the pointer wraps DEPTH-1 -> 0. trig_i=1 -> CAPTURING.
//   The trigger sample is written in this same cycle and counts as the first post sample.
//  CAPTURING (SINGLE_SHOT): write until DEPTH-TRIGGER_LOC post samples total -> CAPTURED.
//  CAPTURING (INCREMENTAL): write only on cycles with trig_i=1 until DEPTH writes -> CAPTURED.
//  CAPTURED: no writes. READ_POINTER = final write pointer, i.e. the next address after the last write,
//   mod DEPTH. This is 0 for IMMEDIATE/INCREMENTAL.
//  Stop edge in any state -> IDLE on the next cycle; no further writes.
//  Write path: probe_i is sampled at edge N; wr_en_o/wr_data_o/wr_addr_o are valid after edge N,
//   i.e. one cycle of latency.
//  The write pointer increments after each write, mod DEPTH.
//  The pointer is exposed as WRITE_POINTER, zero-extended to 16 bits.
// TESTING
//  1 Reset, read +0..+6 and a foreign address -> all 0; foreign read returns rdata_i, valid_o one cycle later.
//  2 DEPTH=16, SINGLE_SHOT, LOC=4, probe=cycle counter, trig_i at probe=10 (already IN_POSITION)
//    -> CAPTURED; memory read from READ_POINTER yields 6..21.
//  3 IMMEDIATE, DEPTH=16 -> exactly 16 wr_en_o pulses at addrs 0..15; STATE=4; READ_POINTER=0.
//  4 INCREMENTAL, trig_i high every 3rd cycle -> 16 writes only on trig cycles, addrs 0..15, then CAPTURED.
//  5 Write LOC=20 (DEPTH=16) -> reads 15; stop edge during IN_POSITION -> STATE=0 next cycle, wr_en_o=0.
//  6 Assert rst mid-CAPTURING -> wr_en_o and STATE go to 0 with no clock edge; a re-start then works.

Source files
------------

// File: rtl/la_capture_fsm.sv
// Capture controller for the logic analyzer: sequences pre/post-trigger capture into a
// circular sample memory and exposes its control/status registers on the daisy-chained bus.
module la_capture_fsm #(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned SAMPLE_DEPTH = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SAMPLE_WIDTH-1:0]         probe_i,
  input  logic                            trig_i,
  input  logic [15:0]                     addr_i,
  input  logic [15:0]                     wdata_i,
  input  logic [15:0]                     rdata_i,
  input  logic                            rw_i,
  input  logic                            valid_i,
  output logic [15:0]                     addr_o,
  output logic [15:0]                     wdata_o,
  output logic [15:0]                     rdata_o,
  output logic                            rw_o,
  output logic                            valid_o,
  output logic [$clog2(SAMPLE_DEPTH)-1:0] wr_addr_o,
  output logic [SAMPLE_WIDTH-1:0]         wr_data_o,
  output logic                            wr_en_o
);

  localparam int unsigned AW = $clog2(SAMPLE_DEPTH);
  localparam int unsigned CW = $clog2(SAMPLE_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(SAMPLE_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(SAMPLE_DEPTH);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    MOVE_TO_POSITION = 3'd1,
    IN_POSITION      = 3'd2,
    CAPTURING        = 3'd3,
    CAPTURED         = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_SINGLE_SHOT = 2'd0,
    MODE_INCREMENTAL = 2'd1,
    MODE_IMMEDIATE   = 2'd2
  } mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [AW-1:0]     loc_q, loc_d;
  logic              start_q, start_d, start_prev_q;
  logic              stop_q, stop_d, stop_prev_q;
  logic [AW-1:0]     rp_q, rp_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [SAMPLE_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [15:0]       addr_q, wdata_q, rdata_q, rdata_d;
  logic              rw_q, valid_q;

  logic [15:0]       bus_off;
  logic              bus_hit;
  logic              cfg_ok;
  logic [15:0]       reg_rd;
  logic              start_edge, stop_edge;
  logic [AW-1:0]     wp_next;
  logic [CW-1:0]     cnt_inc;
  logic [CW-1:0]     post_target;

  // ---------------------------------------------------------------------------
  // Register bus decode and register file
  // ---------------------------------------------------------------------------
  assign bus_off = addr_i - 16'(BASE_ADDR);
  assign bus_hit = valid_i && (bus_off < 16'd7);
  assign cfg_ok  = (state_q == IDLE) || (state_q == CAPTURED);

  always_comb begin
    reg_rd = '0;
    case (bus_off[2:0])
      3'd0:    reg_rd = 16'(state_q);
      3'd1:    reg_rd = 16'(mode_q);
      3'd2:    reg_rd = 16'(loc_q);
      3'd3:    reg_rd = 16'(start_q);
      3'd4:    reg_rd = 16'(stop_q);
      3'd5:    reg_rd = 16'(rp_q);
      3'd6:    reg_rd = 16'(wp_q);
      default: reg_rd = '0;
    endcase
  end

  always_comb begin
    mode_d  = mode_q;
    loc_d   = loc_q;
    start_d = start_q;
    stop_d  = stop_q;
    rdata_d = rdata_i;
    if (bus_hit) begin
      if (rw_i) begin
        case (bus_off[2:0])
          3'd1: if (cfg_ok) begin
            case (wdata_i[1:0])
              2'd1:    mode_d = MODE_INCREMENTAL;
              2'd2:    mode_d = MODE_IMMEDIATE;
              default: mode_d = MODE_SINGLE_SHOT;
            endcase
          end
          3'd2: if (cfg_ok) begin
            loc_d = ({16'd0, wdata_i} >= 32'(SAMPLE_DEPTH)) ? LAST_ADDR : wdata_i[AW-1:0];
          end
          3'd3:    start_d = wdata_i[0];
          3'd4:    stop_d  = wdata_i[0];
          default: ;
        endcase
      end else begin
        rdata_d = reg_rd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture sequencer
  // ---------------------------------------------------------------------------
  assign start_edge  = start_q & ~start_prev_q;
  assign stop_edge   = stop_q & ~stop_prev_q;
  assign wp_next     = (wp_q == LAST_ADDR) ? '0 : wp_q + 1'b1;
  assign cnt_inc     = cnt_q + 1'b1;
  assign post_target = (mode_q == MODE_SINGLE_SHOT) ? (DEPTH_C - CW'(loc_q)) : DEPTH_C;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    wr_en_d = 1'b0;
    if (stop_edge) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, CAPTURED: begin
          if (start_edge) begin
            wp_d  = '0;
            cnt_d = '0;
            rp_d  = '0;
            if (mode_q == MODE_SINGLE_SHOT) begin
              state_d = (loc_q == '0) ? IN_POSITION : MOVE_TO_POSITION;
            end else begin
              state_d = CAPTURING;
            end
          end
        end
        MOVE_TO_POSITION: begin
          wr_en_d = 1'b1;
          cnt_d   = cnt_inc;
          if (cnt_inc == CW'(loc_q)) state_d = IN_POSITION;
        end
        IN_POSITION: begin
          wr_en_d = 1'b1;
          // The trigger sample is itself the first post-trigger sample.
          if (trig_i) begin
            cnt_d = CW'(1);
            if (post_target == CW'(1)) begin
              state_d = CAPTURED;
              rp_d    = wp_next;
            end else begin
              state_d = CAPTURING;
            end
          end
        end
        CAPTURING: begin
          wr_en_d = (mode_q == MODE_INCREMENTAL) ? trig_i : 1'b1;
          if (wr_en_d) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_target) begin
              state_d = CAPTURED;
              rp_d    = wp_next;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (wr_en_d) wp_d = wp_next;
  end

  assign wr_addr_d = wr_en_d ? wp_q : wr_addr_q;
  assign wr_data_d = wr_en_d ? probe_i : wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_SINGLE_SHOT;
      loc_q        <= '0;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      stop_q       <= 1'b0;
      stop_prev_q  <= 1'b0;
      rp_q         <= '0;
      wp_q         <= '0;
      cnt_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rw_q         <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      loc_q        <= loc_d;
      start_q      <= start_d;
      start_prev_q <= start_q;
      stop_q       <= stop_d;
      stop_prev_q  <= stop_q;
      rp_q         <= rp_d;
      wp_q         <= wp_d;
      cnt_q        <= cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      addr_q       <= addr_i;
      wdata_q      <= wdata_i;
      rdata_q      <= rdata_d;
      rw_q         <= rw_i;
      valid_q      <= valid_i;
    end
  end

  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign rdata_o   = rdata_q;
  assign rw_o      = rw_q;
  assign valid_o   = valid_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_la_capture_fsm.sv
// Self-checking bench for la_capture_fsm: register table vectors, directed capture
// sequences and randomized captures checked against a sample-stream reference model.
module tb_la_capture_fsm;

  localparam int unsigned W = 8;
  localparam int unsigned D = 16;
  localparam logic [15:0] BASE = 16'h0020;
  localparam int OFF_ST = 0, OFF_MODE = 1, OFF_LOC = 2, OFF_START = 3,
                 OFF_STOP = 4, OFF_RP = 5, OFF_WP = 6;

  logic         clk, rst;
  logic [W-1:0] probe_i;
  logic         trig_i;
  logic [15:0]  addr_i, wdata_i, rdata_i;
  logic         rw_i, valid_i;
  logic [15:0]  addr_o, wdata_o, rdata_o;
  logic         rw_o, valid_o;
  logic [3:0]   wr_addr_o;
  logic [W-1:0] wr_data_o;
  logic         wr_en_o;

  la_capture_fsm #(
    .BASE_ADDR   (32'h20),
    .SAMPLE_WIDTH(W),
    .SAMPLE_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .probe_i(probe_i), .trig_i(trig_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_en_o(wr_en_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]   a;
    logic [W-1:0] d;
  } wr_t;

  wr_t          got_q[$];
  wr_t          exp_q[$];
  logic [W-1:0] mem [0:D-1];
  logic [W-1:0] plog[0:8191];
  logic         tlog[0:8191];
  int           cyc = 0;

  // Stimulus seen by the DUT at every rising edge, indexed by edge number.
  always @(posedge clk) begin
    if (cyc < 8192) begin
      plog[cyc] <= probe_i;
      tlog[cyc] <= trig_i;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (wr_en_o) begin
      got_q.push_back('{a: wr_addr_o, d: wr_data_o});
      mem[wr_addr_o] <= wr_data_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic bus_wr(input int off, input logic [15:0] d);
    addr_i  = BASE + 16'(off);
    wdata_i = d;
    rw_i    = 1'b1;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    rw_i    = 1'b0;
  endtask

  task automatic check_rd(input string nm, input logic [15:0] a, input logic [15:0] exp);
    addr_i  = a;
    rw_i    = 1'b0;
    valid_i = 1'b1;
    rdata_i = 16'($urandom);
    @(posedge clk); #1;
    check(nm, rdata_o, exp);
    check({nm, "_valid"}, valid_o, 1'b1);
    valid_i = 1'b0;
  endtask

  task automatic do_start(input int mode, input int loc, output int s0);
    bus_wr(OFF_STOP, 16'd0);
    bus_wr(OFF_START, 16'd0);
    bus_wr(OFF_MODE, 16'(mode));
    bus_wr(OFF_LOC, 16'(loc));
    got_q.delete();
    bus_wr(OFF_START, 16'd1);
    // Edge detected one edge later; the first sample is taken on the edge after that.
    s0 = cyc + 1;
  endtask

  task automatic run_random(input int n, input int pct);
    repeat (n) begin
      @(posedge clk); #1;
      probe_i = W'($urandom);
      trig_i  = ($urandom_range(0, 99) < pct);
    end
    trig_i = 1'b0;
  endtask

  // Expected writes derived from the logged sample stream and the capture rules.
  task automatic model(input int mode, input int loc, input int s0, input int s1);
    int trig_at;
    int n;
    exp_q.delete();
    trig_at = -1;
    n = 0;
    for (int i = 0; s0 + i < s1; i++) begin
      if (mode == 0) begin
        exp_q.push_back('{a: 4'(i % D), d: plog[s0 + i]});
        if (trig_at < 0 && i >= loc && tlog[s0 + i]) trig_at = i;
        if (trig_at >= 0 && (i - trig_at + 1) == (D - loc)) break;
      end else if (mode == 1) begin
        if (tlog[s0 + i]) begin
          exp_q.push_back('{a: 4'(n % D), d: plog[s0 + i]});
          n++;
          if (n == D) break;
        end
      end else begin
        exp_q.push_back('{a: 4'(i), d: plog[s0 + i]});
        if (i == D - 1) break;
      end
    end
  endtask

  task automatic compare_capture(input string nm);
    int bad;
    bad = 0;
    check({nm, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i].a !== exp_q[i].a || got_q[i].d !== exp_q[i].d) bad++;
    check({nm, "_wrseq_bad"}, bad, 0);
    check_rd({nm, "_state"}, BASE + 16'(OFF_ST), 16'd4);
    check_rd({nm, "_rp"}, BASE + 16'(OFF_RP), 16'(exp_q.size() % D));
    check_rd({nm, "_wp"}, BASE + 16'(OFF_WP), 16'(exp_q.size() % D));
  endtask

  typedef struct {
    int          off;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int s0;
    int mode, loc, pct;

    tbl = '{
      '{OFF_MODE, 16'd2, 16'd2},   '{OFF_MODE, 16'd3, 16'd0},
      '{OFF_MODE, 16'd1, 16'd1},   '{OFF_MODE, 16'd0, 16'd0},
      '{OFF_LOC, 16'd20, 16'd15},  '{OFF_LOC, 16'd16, 16'd15},
      '{OFF_LOC, 16'd15, 16'd15},  '{OFF_LOC, 16'hFFFF, 16'd15},
      '{OFF_LOC, 16'd7, 16'd7},    '{OFF_LOC, 16'd0, 16'd0},
      '{OFF_ST, 16'd3, 16'd0},     '{OFF_RP, 16'd9, 16'd0},
      '{OFF_WP, 16'd9, 16'd0}
    };

    rst = 1'b1; probe_i = '0; trig_i = 1'b0;
    addr_i = '0; wdata_i = '0; rdata_i = '0; rw_i = 1'b0; valid_i = 1'b0;
    #12;
    check("rst_wr_en", wr_en_o, 1'b0);
    check("rst_valid_o", valid_o, 1'b0);
    check("rst_rdata_o", rdata_o, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) check_rd($sformatf("rst_reg%0d", i), BASE + 16'(i), 16'd0);

    // Foreign read: rdata_i passes through one cycle later.
    addr_i = 16'h0100; rw_i = 1'b0; valid_i = 1'b1; rdata_i = 16'hBEEF;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("foreign_rdata", rdata_o, 16'hBEEF);
    check("foreign_addr", addr_o, 16'h0100);
    check("foreign_valid", valid_o, 1'b1);
    @(posedge clk); #1;
    check("foreign_valid_drop", valid_o, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus_wr(tbl[i].off, tbl[i].wd);
      check_rd($sformatf("tbl%0d", i), BASE + 16'(tbl[i].off), tbl[i].exp);
    end

    // Single shot, LOC=4, probe = sample index, trigger at sample 10.
    do_start(0, 4, s0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      probe_i = W'(k);
      trig_i  = (k == 10);
    end
    trig_i = 1'b0;
    check("ss_nwr", got_q.size(), 22);
    check_rd("ss_state", BASE + 16'(OFF_ST), 16'd4);
    check_rd("ss_rp", BASE + 16'(OFF_RP), 16'd6);
    for (int i = 0; i < D; i++) check($sformatf("ss_mem%0d", i), mem[(6 + i) % D], W'(6 + i));

    // Stop during IN_POSITION; config writes are locked while armed.
    do_start(0, 4, s0);
    run_random(12, 0);
    bus_wr(OFF_MODE, 16'd2);
    check_rd("locked_mode", BASE + 16'(OFF_MODE), 16'd0);
    check_rd("armed_state", BASE + 16'(OFF_ST), 16'd2);
    bus_wr(OFF_STOP, 16'd1);
    @(posedge clk); #1;
    check("stop_wr_en", wr_en_o, 1'b0);
    check_rd("stop_state", BASE + 16'(OFF_ST), 16'd0);
    check("stop_wr_en_later", wr_en_o, 1'b0);

    // Asynchronous reset mid-capture, then a fresh capture.
    do_start(2, 0, s0);
    repeat (5) @(posedge clk);
    #2;
    check("pre_rst_wr_en", wr_en_o, 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_wr_en", wr_en_o, 1'b0);
    check("async_rst_wr_addr", wr_addr_o, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_rd("post_rst_state", BASE + 16'(OFF_ST), 16'd0);
    check_rd("post_rst_mode", BASE + 16'(OFF_MODE), 16'd0);
    do_start(2, 0, s0);
    run_random(40, 50);
    model(2, 0, s0, cyc);
    compare_capture("restart_imm");

    for (int r = 0; r < 9; r++) begin
      mode = (r < 3) ? r : int'($urandom_range(0, 2));
      loc  = int'($urandom_range(0, D - 1));
      pct  = int'($urandom_range(25, 75));
      do_start(mode, loc, s0);
      run_random(300, pct);
      model(mode, loc, s0, cyc);
      compare_capture($sformatf("rnd%0d_m%0d_l%0d", r, mode, loc));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
